// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl
// Hazard/stall controller for the F/D and D/E pipeline registers. It compares
// when D needs its operands (Tuse) with when results in E/M become
// forwardable (Tnew). It also tracks a multi-cycle mult/div unit with a busy
// down-counter. The result is one stall decision per cycle: freeze PC and F/D,
// and flush D/E (insert a bubble).
//
// Parameters:
//   MULT_CYCLES  busy cycles after a mult/multu start (1..15)
//   DIV_CYCLES   busy cycles after a div/divu start  (1..15)
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   D_rs_addr/D_rt_addr source register indices of the instruction in D
//   D_tuse_rs/D_tuse_rt cycles until D needs rs/rt (3 = never)
//   D_is_md             D instruction uses the mult/div unit
//   E_A3/E_tnew         destination and Tnew of the instruction in E
//   M_A3/M_tnew         destination and Tnew of the instruction in M
//   E_md_start          mult/div start pulse from E
//   E_md_type           0 = mult/multu, 1 = div/divu
//   PC_WE, D_WE         PC and F/D write enables (low while stalling)
//   E_Flush             D/E flush (high while stalling)
//   md_busy             mult/div unit busy
//   stall               stall decision (debug)
//
// Optional build macro STALL_STATS_EN adds the following 32-bit saturating
// counters:
//   stall_cnt           edges with stall = 1
//   md_stall_cnt        edges with a mult/div-caused stall
// -----------------------------------------------------------------------------
module stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_A3,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_type,
    output logic        PC_WE,
    output logic        D_WE,
    output logic        E_Flush,
    output logic        md_busy,
    output logic        stall
`ifdef STALL_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] md_stall_cnt
`endif
);

    logic [3:0] cnt_q, cnt_d;
    logic       stall_rs, stall_rt, stall_md;

    // A destination of $0 can never match, because a nonzero source address is required.
    always_comb begin
        stall_rs = (D_rs_addr != 5'd0) &&
                   (((E_A3 == D_rs_addr) && (E_tnew > D_tuse_rs)) ||
                    ((M_A3 == D_rs_addr) && (M_tnew > D_tuse_rs)));
        stall_rt = (D_rt_addr != 5'd0) &&
                   (((E_A3 == D_rt_addr) && (E_tnew > D_tuse_rt)) ||
                    ((M_A3 == D_rt_addr) && (M_tnew > D_tuse_rt)));
        stall_md = D_is_md && (md_busy || E_md_start);
        stall    = stall_rs || stall_rt || stall_md;
        PC_WE    = ~stall;
        D_WE     = ~stall;
        E_Flush  = stall;
    end

    assign md_busy = (cnt_q != 4'd0);

    // A start loads the counter even when it arrives with a stall, because the
    // flush only affects the next instruction in E. A start that arrives while the
    // unit is already busy is dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (E_md_start && (cnt_q == 4'd0))
            cnt_d = E_md_type ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        else if (cnt_q != 4'd0)
            cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= 4'd0;
        else
            cnt_q <= cnt_d;
    end

`ifdef STALL_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        md_stall_cnt_d = md_stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (stall_md && (md_stall_cnt_q != 32'hFFFF_FFFF))
            md_stall_cnt_d = md_stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q    <= 32'd0;
            md_stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            md_stall_cnt_q <= md_stall_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
module tb_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs_addr, D_rt_addr, E_A3, M_A3;
    logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic       D_is_md, E_md_start, E_md_type;
    logic       PC_WE, D_WE, E_Flush, md_busy, stall;
`ifdef STALL_STATS_EN
    logic [31:0] stall_cnt, md_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stall_ctrl dut (
        .clk(clk), .reset(reset),
        .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .D_is_md(D_is_md),
        .E_A3(E_A3), .E_tnew(E_tnew), .M_A3(M_A3), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_type(E_md_type),
        .PC_WE(PC_WE), .D_WE(D_WE), .E_Flush(E_Flush),
        .md_busy(md_busy), .stall(stall)
`ifdef STALL_STATS_EN
        , .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt)
`endif
    );

    // The output vector is {PC_WE, D_WE, E_Flush, stall, md_busy}.
    logic [4:0] obs;
    assign obs = {PC_WE, D_WE, E_Flush, stall, md_busy};

    localparam logic [4:0] RUN_IDLE  = 5'b11000;
    localparam logic [4:0] RUN_BUSY  = 5'b11001;
    localparam logic [4:0] STALL_IDL = 5'b00110;
    localparam logic [4:0] STALL_BSY = 5'b00111;

    task automatic clear_inputs();
        D_rs_addr = 0; D_rt_addr = 0; D_tuse_rs = 0; D_tuse_rt = 0;
        D_is_md = 0; E_A3 = 0; E_tnew = 0; M_A3 = 0; M_tnew = 0;
        E_md_start = 0; E_md_type = 0;
    endtask

    // Inputs change on the falling edge. Outputs are sampled 2 ns later, away from the rising edge.
    task automatic next_slot();
        @(negedge clk);
    endtask

    task automatic test_reset();
        next_slot();
        reset = 1'b1;
        clear_inputs();
        next_slot();
        next_slot();
        #2;
        checks++;
        if (obs !== RUN_IDLE) begin
            errors++;
            $display("FAIL reset_outputs got %b want %b", obs, RUN_IDLE);
        end
`ifdef STALL_STATS_EN
        checks++;
        if (stall_cnt !== 32'd0 || md_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats got %0d/%0d want 0/0", stall_cnt, md_stall_cnt);
        end
`endif
        next_slot();
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        next_slot();
        clear_inputs();
        E_A3 = 5; E_tnew = 2; D_rs_addr = 5; D_tuse_rs = 1;
        #2;
        checks++;
        if (obs !== STALL_IDL) begin
            errors++;
            $display("FAIL load_use_stall got %b want %b", obs, STALL_IDL);
        end
        next_slot();
        E_A3 = 0; E_tnew = 0; M_A3 = 5; M_tnew = 1;
        #2;
        checks++;
        if (obs !== RUN_IDLE) begin
            errors++;
            $display("FAIL load_use_release got %b want %b", obs, RUN_IDLE);
        end
        // A hazard on rt against M: Tnew 2 is greater than Tuse 1, so D must stall.
        next_slot();
        clear_inputs();
        M_A3 = 9; M_tnew = 2; D_rt_addr = 9; D_tuse_rt = 1;
        #2;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL rt_m_hazard got %b want 1", stall);
        end
        // Tnew equal to Tuse means the result can be forwarded in time, so there is no stall.
        next_slot();
        clear_inputs();
        E_A3 = 12; E_tnew = 1; D_rs_addr = 12; D_tuse_rs = 1;
        #2;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL tnew_eq_tuse got %b want 0", stall);
        end
        // A matching address with Tuse=3 (never used) must not stall.
        next_slot();
        clear_inputs();
        E_A3 = 12; E_tnew = 2; D_rt_addr = 12; D_tuse_rt = 3;
        #2;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL tuse_never got %b want 0", stall);
        end
    endtask

    task automatic test_zero_guard();
        next_slot();
        clear_inputs();
        E_A3 = 0; E_tnew = 2; D_rs_addr = 0; D_tuse_rs = 0;
        #2;
        checks++;
        if (obs !== RUN_IDLE) begin
            errors++;
            $display("FAIL zero_guard_rs got %b want %b", obs, RUN_IDLE);
        end
        next_slot();
        M_A3 = 0; M_tnew = 2; D_rt_addr = 0; D_tuse_rt = 0;
        #2;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL zero_guard_rt got %b want 0", stall);
        end
    endtask

    task automatic test_tuse_ok();
        next_slot();
        clear_inputs();
        M_A3 = 7; M_tnew = 1; D_rt_addr = 7; D_tuse_rt = 1;
        #2;
        checks++;
        if (obs !== RUN_IDLE) begin
            errors++;
            $display("FAIL tuse_ok got %b want %b", obs, RUN_IDLE);
        end
        // A different register with a large Tnew must not stall.
        next_slot();
        E_A3 = 8; E_tnew = 2; D_rs_addr = 6; D_tuse_rs = 0;
        #2;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL addr_mismatch got %b want 0", stall);
        end
    endtask

    task automatic test_div_busy();
        next_slot();
        clear_inputs();
        D_is_md = 1; E_md_start = 1; E_md_type = 1;
        #2;
        checks++;
        if (obs !== STALL_IDL) begin
            errors++;
            $display("FAIL div_start_cycle got %b want %b", obs, STALL_IDL);
        end
        next_slot();
        E_md_start = 0;
        for (int i = 0; i < 10; i++) begin
            #2;
            checks++;
            if (obs !== STALL_BSY) begin
                errors++;
                $display("FAIL div_busy_cycle%0d got %b want %b", i, obs, STALL_BSY);
            end
            next_slot();
        end
        #2;
        checks++;
        if (obs !== RUN_IDLE) begin
            errors++;
            $display("FAIL div_done got %b want %b", obs, RUN_IDLE);
        end
    endtask

    task automatic test_start_no_md();
        // A start pulse with a non-mult/div instruction in D loads the counter but does not stall.
        next_slot();
        clear_inputs();
        E_md_start = 1; E_md_type = 0;
        #2;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL start_no_md got %b want 0", stall);
        end
        next_slot();
        E_md_start = 0;
        // Check busy for 5 cycles. Redundant start pulses are ignored.
        for (int i = 0; i < 5; i++) begin
            E_md_start = (i == 1);
            E_md_type  = 1'b1;
            #2;
            checks++;
            if (obs !== RUN_BUSY) begin
                errors++;
                $display("FAIL mult_busy_cycle%0d got %b want %b", i, obs, RUN_BUSY);
            end
            next_slot();
        end
        E_md_start = 0;
        #2;
        checks++;
        if (md_busy !== 1'b0) begin
            errors++;
            $display("FAIL mult_no_reload got %b want 0", md_busy);
        end
    endtask

    task automatic test_reset_mid_op();
        next_slot();
        clear_inputs();
        D_is_md = 1; E_md_start = 1; E_md_type = 0;
        next_slot();
        E_md_start = 0;
        next_slot();
        next_slot();
        // This is the 3rd busy cycle. Reset takes effect at the next edge.
        #2;
        checks++;
        if (obs !== STALL_BSY) begin
            errors++;
            $display("FAIL mult_third_busy got %b want %b", obs, STALL_BSY);
        end
`ifdef STALL_STATS_EN
        // Stall edges so far: the start cycle plus 2 busy cycles = 3.
        checks++;
        if (stall_cnt === 32'd0 || md_stall_cnt === 32'd0) begin
            errors++;
            $display("FAIL stats_counting got %0d/%0d want nonzero", stall_cnt, md_stall_cnt);
        end
`endif
        reset = 1'b1;
        next_slot();
        reset = 1'b0;
        #2;
        checks++;
        if (obs !== RUN_IDLE) begin
            errors++;
            $display("FAIL reset_mid_op got %b want %b", obs, RUN_IDLE);
        end
`ifdef STALL_STATS_EN
        checks++;
        if (stall_cnt !== 32'd0 || md_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_stats got %0d/%0d want 0/0", stall_cnt, md_stall_cnt);
        end
`endif
        next_slot();
        #2;
        checks++;
        if (md_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_stays_idle got %b want 0", md_busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_zero_guard();
        test_tuse_ok();
        test_div_busy();
        test_start_no_md();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
